// File: rtl/param_register_file.sv
// param_register_file
// Parametrised register file: N = 2**AW registers of W bits, index N-1 is the
// program counter. Two read ports (combinational), two write ports (port 4
// wins on a collision), optional same-cycle write-to-read forwarding, and a
// stallable PC with a configurable reset vector.
module param_register_file #(
   parameter int unsigned   W        = 32,
   parameter int unsigned   AW       = 4,
   parameter bit            BYPASS   = 1'b1,
   parameter logic [W-1:0]  PC_RESET = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] A_1,
   input  logic [AW-1:0] A_2,
   input  logic [AW-1:0] A_3,
   input  logic [W-1:0]  WD3,
   input  logic          wen,
   input  logic [AW-1:0] A_4,
   input  logic [W-1:0]  WD4,
   input  logic          wen4,
   input  logic [W-1:0]  R15,
   input  logic          pc_wen,
   output logic [W-1:0]  RD1,
   output logic [W-1:0]  RD2,
   output logic [W-1:0]  PC_out
);

   localparam int unsigned   N      = 2**AW;
   localparam logic [AW-1:0] PC_IDX = AW'(N - 1);

   // General-purpose registers 0..N-2; the PC lives in its own register.
   logic [W-1:0] r_gpr [0:N-2];
   logic [W-1:0] r_pc;

   // Full N-entry view of the architectural state, indexed by read address.
   logic [W-1:0] w_view [0:N-1];

   // Per-register write strobes after port-4-over-port-3 priority.
   logic [N-2:0] w_we3;
   logic [N-2:0] w_we4;

   logic [W-1:0] w_rd1;
   logic [W-1:0] w_rd2;

   // Resolve one read port: forward pending write data (port 4 first) to a
   // general register address when forwarding is enabled and not in reset;
   // the PC index always returns the stored PC.
   function automatic logic [W-1:0] f_resolve(
      input logic [AW-1:0] addr,
      input logic [W-1:0]  stored,
      input logic          rst,
      input logic          we3,
      input logic [AW-1:0] a3,
      input logic [W-1:0]  wd3,
      input logic          we4,
      input logic [AW-1:0] a4,
      input logic [W-1:0]  wd4
   );
      logic [W-1:0] res;
      res = stored;
      if (BYPASS && !rst && (addr != PC_IDX)) begin
         if (we4 && (a4 == addr)) begin
            res = wd4;
         end else if (we3 && (a3 == addr)) begin
            res = wd3;
         end else begin
            res = stored;
         end
      end else begin
         res = stored;
      end
      return res;
   endfunction

   // Decode write addresses into per-register strobes; the PC index is never
   // decoded, so port writes to it fall on the floor.
   always_comb begin
      for (int k = 0; k < int'(N) - 1; k++) begin
         w_we4[k] = wen4 && (A_4 == AW'(k));
         w_we3[k] = wen && (A_3 == AW'(k)) && !w_we4[k];
      end
   end

   // Register array and PC update; reset overrides every write and the PC load.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < int'(N) - 1; k++) begin
            r_gpr[k] <= '0;
         end
         r_pc <= PC_RESET;
      end else begin
         for (int k = 0; k < int'(N) - 1; k++) begin
            if (w_we4[k]) begin
               r_gpr[k] <= WD4;
            end else if (w_we3[k]) begin
               r_gpr[k] <= WD3;
            end else begin
               r_gpr[k] <= r_gpr[k];
            end
         end
         if (pc_wen) begin
            r_pc <= R15;
         end else begin
            r_pc <= r_pc;
         end
      end
   end

   // Assemble the addressable view: general registers followed by the PC.
   always_comb begin
      for (int k = 0; k < int'(N) - 1; k++) begin
         w_view[k] = r_gpr[k];
      end
      w_view[N-1] = r_pc;
   end

   // Read port 1 with optional forwarding.
   always_comb begin
      w_rd1 = f_resolve(A_1, w_view[A_1], reset, wen, A_3, WD3, wen4, A_4, WD4);
   end

   // Read port 2 with optional forwarding.
   always_comb begin
      w_rd2 = f_resolve(A_2, w_view[A_2], reset, wen, A_3, WD3, wen4, A_4, WD4);
   end

   assign RD1    = w_rd1;
   assign RD2    = w_rd2;
   assign PC_out = r_pc;

endmodule

// File: tb/tb_param_register_file.sv
// Testbench for param_register_file: a forwarding instance, a non-forwarding
// instance sharing the same stimulus, and a small AW=3/W=16 instance.
module tb_param_register_file;

   logic clk;
   logic reset;

   // Shared stimulus for the two 16x32 instances.
   logic [3:0]  a1, a2, a3, a4;
   logic [31:0] wd3, wd4, r15;
   logic        wen, wen4, pcw;
   logic [31:0] rd1, rd2, pc;
   logic [31:0] nb_rd1, nb_rd2, nb_pc;

   // Small instance stimulus.
   logic [2:0]  s_a1, s_a2, s_a3, s_a4;
   logic [15:0] s_wd3, s_wd4, s_r15;
   logic        s_wen, s_wen4, s_pcw;
   logic [15:0] s_rd1, s_rd2, s_pc;

   int errors = 0;
   int checks = 0;

   param_register_file #(.W(32), .AW(4), .BYPASS(1'b1), .PC_RESET(32'h100)) dut (
      .clk(clk), .reset(reset), .A_1(a1), .A_2(a2), .A_3(a3), .WD3(wd3), .wen(wen),
      .A_4(a4), .WD4(wd4), .wen4(wen4), .R15(r15), .pc_wen(pcw),
      .RD1(rd1), .RD2(rd2), .PC_out(pc));

   param_register_file #(.W(32), .AW(4), .BYPASS(1'b0), .PC_RESET(32'h100)) dut_nb (
      .clk(clk), .reset(reset), .A_1(a1), .A_2(a2), .A_3(a3), .WD3(wd3), .wen(wen),
      .A_4(a4), .WD4(wd4), .wen4(wen4), .R15(r15), .pc_wen(pcw),
      .RD1(nb_rd1), .RD2(nb_rd2), .PC_out(nb_pc));

   param_register_file #(.W(16), .AW(3), .BYPASS(1'b1), .PC_RESET(16'h10)) dut_s (
      .clk(clk), .reset(reset), .A_1(s_a1), .A_2(s_a2), .A_3(s_a3), .WD3(s_wd3), .wen(s_wen),
      .A_4(s_a4), .WD4(s_wd4), .wen4(s_wen4), .R15(s_r15), .pc_wen(s_pcw),
      .RD1(s_rd1), .RD2(s_rd2), .PC_out(s_pc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  a1, a2, a3;
      logic [31:0] wd3;
      logic        wen;
      logic [3:0]  a4;
      logic [31:0] wd4;
      logic        wen4;
      logic [31:0] r15;
      logic        pcw;
      logic [31:0] e1, e2, enb1, epc;
   } vec_t;

   vec_t vecs [13];

   // Reference model state (shared by both 16x32 instances).
   logic [31:0] m_reg [16];
   logic [31:0] m_pc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [3:0] addr, input bit byp);
      if (addr == 4'd15) return m_pc;
      if (byp && !reset) begin
         if (wen4 && a4 == addr) return wd4;
         if (wen && a3 == addr) return wd3;
      end
      return m_reg[addr];
   endfunction

   task automatic model_step();
      if (reset) begin
         for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
         m_pc = 32'h100;
      end else begin
         if (wen && a3 != 4'd15) m_reg[a3] = wd3;
         if (wen4 && a4 != 4'd15) m_reg[a4] = wd4;
         if (pcw) m_pc = r15;
      end
   endtask

   task automatic idle_main();
      a1 = 4'd0; a2 = 4'd0; a3 = 4'd0; a4 = 4'd0;
      wd3 = 32'h0; wd4 = 32'h0; r15 = 32'h0;
      wen = 1'b0; wen4 = 1'b0; pcw = 1'b0;
   endtask

   task automatic idle_small();
      s_a1 = 3'd0; s_a2 = 3'd0; s_a3 = 3'd0; s_a4 = 3'd0;
      s_wd3 = 16'h0; s_wd4 = 16'h0; s_r15 = 16'h0;
      s_wen = 1'b0; s_wen4 = 1'b0; s_pcw = 1'b0;
   endtask

   initial begin
      //            rst   a1     a2     a3     wd3            wen   a4     wd4           wen4  r15           pcw   e1             e2             enb1           epc
      vecs[0]  = '{1'b0, 4'd0,  4'd15, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         32'h100,       32'h0,         32'h100};
      vecs[1]  = '{1'b0, 4'd2,  4'd2,  4'd2,  32'hDEADBEEF,  1'b1, 4'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'hDEADBEEF,  32'hDEADBEEF,  32'h0,         32'h100};
      vecs[2]  = '{1'b0, 4'd2,  4'd5,  4'd5,  32'h11,        1'b1, 4'd5,  32'h22,       1'b1, 32'h0,        1'b0, 32'hDEADBEEF,  32'h22,        32'hDEADBEEF,  32'h100};
      vecs[3]  = '{1'b0, 4'd5,  4'd6,  4'd6,  32'h33,        1'b1, 4'd7,  32'h44,       1'b1, 32'h0,        1'b0, 32'h22,        32'h33,        32'h22,        32'h100};
      vecs[4]  = '{1'b0, 4'd6,  4'd7,  4'd0,  32'h0,         1'b0, 4'd0,  32'h0,        1'b0, 32'h200,      1'b1, 32'h33,        32'h44,        32'h33,        32'h100};
      vecs[5]  = '{1'b0, 4'd15, 4'd7,  4'd0,  32'h0,         1'b0, 4'd0,  32'h0,        1'b0, 32'h300,      1'b0, 32'h200,       32'h44,        32'h200,       32'h200};
      vecs[6]  = '{1'b0, 4'd15, 4'd7,  4'd0,  32'h0,         1'b0, 4'd0,  32'h0,        1'b0, 32'h300,      1'b0, 32'h200,       32'h44,        32'h200,       32'h200};
      vecs[7]  = '{1'b0, 4'd15, 4'd15, 4'd15, 32'h999,       1'b1, 4'd15, 32'h777,      1'b1, 32'h300,      1'b0, 32'h200,       32'h200,       32'h200,       32'h200};
      vecs[8]  = '{1'b0, 4'd15, 4'd3,  4'd3,  32'hAA,        1'b1, 4'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h200,       32'hAA,        32'h200,       32'h200};
      vecs[9]  = '{1'b1, 4'd3,  4'd3,  4'd3,  32'hBB,        1'b1, 4'd3,  32'hCC,       1'b1, 32'h500,      1'b1, 32'hAA,        32'hAA,        32'hAA,        32'h200};
      vecs[10] = '{1'b0, 4'd3,  4'd15, 4'd0,  32'h0,         1'b0, 4'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,         32'h100,       32'h0,         32'h100};
      vecs[11] = '{1'b0, 4'd2,  4'd4,  4'd4,  32'h66,        1'b1, 4'd4,  32'h55,       1'b1, 32'h0,        1'b0, 32'h0,         32'h55,        32'h0,         32'h100};
      vecs[12] = '{1'b0, 4'd4,  4'd4,  4'd0,  32'h0,         1'b0, 4'd0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h55,        32'h55,        32'h55,        32'h100};

      idle_main();
      idle_small();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #2;

      // Reset readback on every address of both ports.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         a1 = 4'(i);
         a2 = 4'(15 - i);
         #2;
         chk("reset_rd1", {32'h0, rd1}, (i == 15) ? 64'h100 : 64'h0);
         chk("reset_rd2", {32'h0, rd2}, (i == 0) ? 64'h100 : 64'h0);
         chk("reset_nb_rd1", {32'h0, nb_rd1}, (i == 15) ? 64'h100 : 64'h0);
      end
      chk("reset_pc", {32'h0, pc}, 64'h100);
      chk("reset_small_pc", {48'h0, s_pc}, 64'h10);

      // Directed table.
      for (int v = 0; v < 13; v++) begin
         @(negedge clk);
         reset = vecs[v].rst;
         a1 = vecs[v].a1; a2 = vecs[v].a2; a3 = vecs[v].a3; wd3 = vecs[v].wd3; wen = vecs[v].wen;
         a4 = vecs[v].a4; wd4 = vecs[v].wd4; wen4 = vecs[v].wen4; r15 = vecs[v].r15; pcw = vecs[v].pcw;
         #2;
         chk($sformatf("vec%0d_rd1", v), {32'h0, rd1}, {32'h0, vecs[v].e1});
         chk($sformatf("vec%0d_rd2", v), {32'h0, rd2}, {32'h0, vecs[v].e2});
         chk($sformatf("vec%0d_nb_rd1", v), {32'h0, nb_rd1}, {32'h0, vecs[v].enb1});
         chk($sformatf("vec%0d_pc", v), {32'h0, pc}, {32'h0, vecs[v].epc});
         chk($sformatf("vec%0d_nb_pc", v), {32'h0, nb_pc}, {32'h0, vecs[v].epc});
      end
      @(negedge clk);
      reset = 1'b0;
      idle_main();

      // Small instance: write R6 with forwarding, then read back and read PC.
      s_a1 = 3'd6; s_a3 = 3'd6; s_wd3 = 16'h1234; s_wen = 1'b1; s_a2 = 3'd7;
      #2;
      chk("small_bypass_rd1", {48'h0, s_rd1}, 64'h1234);
      chk("small_pc_rd2", {48'h0, s_rd2}, 64'h10);
      @(negedge clk);
      s_wen = 1'b0; s_wd3 = 16'h0; s_a2 = 3'd6; s_a1 = 3'd7;
      #2;
      chk("small_stored_rd2", {48'h0, s_rd2}, 64'h1234);
      chk("small_pc_rd1", {48'h0, s_rd1}, 64'h10);
      chk("small_pc_out", {48'h0, s_pc}, 64'h10);

      // Randomized phase against the reference model; start from a known reset.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
      m_pc = 32'h100;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 31) == 0);
         a1 = 4'($urandom_range(0, 15));
         a2 = ($urandom_range(0, 3) == 0) ? a1 : 4'($urandom_range(0, 15));
         a3 = ($urandom_range(0, 1) == 0) ? a1 : 4'($urandom_range(0, 15));
         a4 = ($urandom_range(0, 2) == 0) ? a3 : 4'($urandom_range(0, 15));
         wd3 = $urandom; wd4 = $urandom; r15 = $urandom;
         wen = 1'($urandom_range(0, 1));
         wen4 = 1'($urandom_range(0, 1));
         pcw = ($urandom_range(0, 3) == 0);
         #2;
         chk("rand_rd1", {32'h0, rd1}, {32'h0, model_read(a1, 1'b1)});
         chk("rand_rd2", {32'h0, rd2}, {32'h0, model_read(a2, 1'b1)});
         chk("rand_nb_rd1", {32'h0, nb_rd1}, {32'h0, model_read(a1, 1'b0)});
         chk("rand_nb_rd2", {32'h0, nb_rd2}, {32'h0, model_read(a2, 1'b0)});
         chk("rand_pc", {32'h0, pc}, {32'h0, m_pc});
         model_step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
Parametrised successor to the 16x32 single-cycle register file. Generalised in data width and register count. Adds a second write port for load/writeback paths, optional write-to-read bypass, a PC stall enable, and a configurable PC reset vector. Sits in the datapath between instruction decode and the ALU. The top register index is the program counter.

Parameters:
W, 32, data width of every register and data port
AW, 4, address width; register count N = 2**AW; index N-1 is the PC
BYPASS, 1, 1 = same-cycle write data is forwarded to read ports; 0 = reads return stored value only
PC_RESET, 0, W-bit value loaded into the PC register on reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
A_1  input  AW  read address, port 1
A_2  input  AW  read address, port 2
A_3  input  AW  write address, port 3
WD3  input  W  write data, port 3
wen  input  1  write enable, port 3
A_4  input  AW  write address, port 4
WD4  input  W  write data, port 4
wen4  input  1  write enable, port 4
R15  input  W  next-PC value
pc_wen  input  1  PC load enable; 0 = PC holds (stall)
RD1  output  W  read data, port 1
RD2  output  W  read data, port 2
PC_out  output  W  current PC register contents

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All state updates happen on the rising edge of clk.
- Reset (reset=1 at an edge):
  - Registers 0..N-2 load 0; PC loads PC_RESET.
  - Reset dominates every write enable and pc_wen in that cycle.
  - Reset asserted while writes are pending: those writes are discarded.
- Write, general registers 0..N-2:
  - Register k loads WD3 if wen=1 and A_3=k. It loads WD4 if wen4=1 and A_4=k.
  - Both ports hit the same k in one cycle: port 4 wins, WD4 is stored.
  - Different addresses on the two ports: both are written in the same cycle.
- PC register (index N-1):
  - Loads R15 when pc_wen=1 and reset=0; otherwise holds.
  - Writes to index N-1 through port 3 or port 4 are ignored and never alter the PC.
- Read (combinational, zero latency): RD1/RD2 = contents of the register at A_1/A_2.
  - BYPASS=1 and reset=0: if a read address is in 0..N-2 and equals an enabled write address, RD returns that write data. Port 4 data takes priority over port 3.
  - Reading index N-1 always returns the stored PC. No R15 forwarding.
  - BYPASS=0: RD always returns stored contents. Written data is visible from the cycle after the edge.
  - While reset=1, bypass is suppressed and RD shows stored contents.
- PC_out = stored PC, always.
- Output values after reset: RD1=RD2=0 for any address in 0..N-2; PC_out=PC_RESET.
- Addresses are full-range (N entries), so there is no out-of-range case.
- Both read ports may address the same register, including one being written; each port resolves independently.
- Implementation: register array plus priority-decoded write enables, two N:1 read muxes, and a bypass compare per read port per write port. Must elaborate for AW=3..5 and W=8..64.

Test Plan:
- Reset with PC_RESET=0x100, then read all 16 addresses on both ports -> RD=0 for 0..14, RD=0x100 for 15, PC_out=0x100.
- wen=1, A_3=2, WD3=0xDEADBEEF, A_1=2, BYPASS=1 -> RD1=0xDEADBEEF in the same cycle. With BYPASS=0 -> RD1=0 that cycle and 0xDEADBEEF after the edge.
- Same edge: wen=1 A_3=5 WD3=0x11, wen4=1 A_4=5 WD4=0x22 -> R5=0x22. Then A_3=6 WD3=0x33 with A_4=7 WD4=0x44 -> R6=0x33 and R7=0x44 after one edge.
- pc_wen=1, R15=0x200 -> PC_out=0x200. pc_wen=0, R15=0x300 for 3 cycles -> PC_out stays 0x200. wen=1, A_3=15, WD3=0x999 -> PC unchanged.
- Write R3=0xAA, then assert reset together with wen=1 A_3=3 WD3=0xBB -> R3=0 after the edge, and RD1 at A_1=3 shows stored 0xAA (no bypass) while reset is high.
- Parameter sweep AW=3, W=16, PC_RESET=0x10: write 0x1234 to R6, read it back -> RD=0x1234. Reading index 7 returns PC.
